// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller: register-address width,
// forwarding select codes, controller states and a live-writer match helper.
package pipe_hazard_ctrl_pkg;

    localparam int unsigned RADDR_WIDTH = 5;
    localparam int unsigned CNT_WIDTH   = 4;
    localparam int unsigned FWD_WIDTH   = 2;

    typedef enum logic [FWD_WIDTH-1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_MUL_WAIT = 1'b1
    } state_e;

    // $0 is hardwired to zero, so it never matches a writer.
    function automatic logic live_match(input logic                   wr,
                                        input logic [RADDR_WIDTH-1:0] dst,
                                        input logic [RADDR_WIDTH-1:0] src);
        return wr && (dst != '0) && (dst == src);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// One EX operand bypass select: the youngest live writer (MEM before WB) wins.
module fwd_sel
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic       mem_wr_i,
    input  logic [4:0] mem_dst_i,
    input  logic       wb_wr_i,
    input  logic [4:0] wb_dst_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (live_match(mem_wr_i, mem_dst_i, src_i)) begin
            sel_o = FWD_MEM;
        end else if (live_match(wb_wr_i, wb_dst_i, src_i)) begin
            sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forward control for a 5-stage MIPS pipeline with a multi-cycle multiply.
// Define FORWARD_EN to enable EX bypassing; otherwise every RAW dependency stalls in ID.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned MUL_LAT = 4
) (
    input  logic       clk_87,
    input  logic       rst_87,
    input  logic [4:0] id_rs_87,
    input  logic [4:0] id_rt_87,
    input  logic       id_jr_87,
    input  logic [4:0] ex_rs_87,
    input  logic [4:0] ex_rt_87,
    input  logic       ex_mem_read_87,
    input  logic       ex_reg_write_87,
    input  logic [4:0] ex_dst_87,
    input  logic       ex_mul_87,
    input  logic       mem_reg_write_87,
    input  logic [4:0] mem_dst_87,
    input  logic       wb_reg_write_87,
    input  logic [4:0] wb_dst_87,
    input  logic       br_taken_87,
    output logic       stall_pc_87,
    output logic       stall_ifid_87,
    output logic       stall_idex_87,
    output logic       bubble_ex_87,
    output logic       flush_ifid_87,
    output logic       flush_idex_87,
    output logic       flush_exmem_87,
    output logic [1:0] fwd_a_87,
    output logic [1:0] fwd_b_87,
    output logic       busy_87
);

    // The first EX cycle is spent in RUN, so the wait covers MUL_LAT-1 cycles.
    localparam logic [CNT_WIDTH-1:0] CNT_LOAD =
        (MUL_LAT > 1) ? CNT_WIDTH'(MUL_LAT - 2) : '0;

    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] mul_cnt_q, mul_cnt_d;
    logic                 hz_load_use, hz_jr, hz_raw, hz_any;

    assign hz_load_use = ex_mem_read_87 && (ex_dst_87 != '0) &&
                         ((ex_dst_87 == id_rs_87) || (ex_dst_87 == id_rt_87));
    assign hz_jr       = id_jr_87 &&
                         (live_match(ex_reg_write_87, ex_dst_87, id_rs_87) ||
                          live_match(mem_reg_write_87, mem_dst_87, id_rs_87));

`ifdef FORWARD_EN
    assign hz_raw = 1'b0;

    fwd_sel u_fwd_a (
        .src_i     (ex_rs_87),
        .mem_wr_i  (mem_reg_write_87),
        .mem_dst_i (mem_dst_87),
        .wb_wr_i   (wb_reg_write_87),
        .wb_dst_i  (wb_dst_87),
        .sel_o     (fwd_a_87)
    );

    fwd_sel u_fwd_b (
        .src_i     (ex_rt_87),
        .mem_wr_i  (mem_reg_write_87),
        .mem_dst_i (mem_dst_87),
        .wb_wr_i   (wb_reg_write_87),
        .wb_dst_i  (wb_dst_87),
        .sel_o     (fwd_b_87)
    );
`else
    logic unused_ex_srcs;

    // Without bypassing, ID waits until every pending writer has retired from WB.
    assign hz_raw = live_match(ex_reg_write_87,  ex_dst_87,  id_rs_87) ||
                    live_match(ex_reg_write_87,  ex_dst_87,  id_rt_87) ||
                    live_match(mem_reg_write_87, mem_dst_87, id_rs_87) ||
                    live_match(mem_reg_write_87, mem_dst_87, id_rt_87) ||
                    live_match(wb_reg_write_87,  wb_dst_87,  id_rs_87) ||
                    live_match(wb_reg_write_87,  wb_dst_87,  id_rt_87);
    assign fwd_a_87       = FWD_RF;
    assign fwd_b_87       = FWD_RF;
    assign unused_ex_srcs = ^{ex_rs_87, ex_rt_87};
`endif

    assign hz_any = hz_load_use || hz_jr || hz_raw;

    // Next state: a taken branch squashes an in-flight multiply wait.
    always_comb begin
        state_d   = state_q;
        mul_cnt_d = mul_cnt_q;
        if (br_taken_87) begin
            state_d   = ST_RUN;
            mul_cnt_d = '0;
        end else if (state_q == ST_MUL_WAIT) begin
            if (mul_cnt_q == '0) begin
                state_d = ST_RUN;
            end else begin
                mul_cnt_d = mul_cnt_q - CNT_WIDTH'(1);
            end
        end else if (ex_mul_87 && (MUL_LAT > 1)) begin
            state_d   = ST_MUL_WAIT;
            mul_cnt_d = CNT_LOAD;
        end
    end

    always_ff @(posedge clk_87) begin
        if (rst_87) begin
            state_q   <= ST_RUN;
            mul_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    // Control outputs: branch flush, then multiply hold, then ID stall.
    always_comb begin
        stall_pc_87    = 1'b0;
        stall_ifid_87  = 1'b0;
        stall_idex_87  = 1'b0;
        bubble_ex_87   = 1'b0;
        flush_ifid_87  = 1'b0;
        flush_idex_87  = 1'b0;
        flush_exmem_87 = 1'b0;
        busy_87        = (state_q == ST_MUL_WAIT);
        if (br_taken_87) begin
            flush_ifid_87  = 1'b1;
            flush_idex_87  = 1'b1;
            flush_exmem_87 = 1'b1;
        end else if (state_q == ST_MUL_WAIT) begin
            stall_pc_87    = 1'b1;
            stall_ifid_87  = 1'b1;
            stall_idex_87  = 1'b1;
            flush_exmem_87 = 1'b1;
        end else if (hz_any) begin
            stall_pc_87   = 1'b1;
            stall_ifid_87 = 1'b1;
            bubble_ex_87  = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios then random traffic
// against a cycle-count reference model, for MUL_LAT=4 and MUL_LAT=1 instances.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
    logic       id_jr, ex_mem_read, ex_reg_write, ex_mul;
    logic       mem_reg_write, wb_reg_write, br_taken;

    // {stall_pc, stall_ifid, stall_idex, bubble, flush_ifid, flush_idex, flush_exmem, fwd_a, fwd_b, busy}
    wire [11:0] obs4, obs1;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int wait4  = 0;
    int wait1  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MUL_LAT(4)) dut (
        .clk_87(clk), .rst_87(rst),
        .id_rs_87(id_rs), .id_rt_87(id_rt), .id_jr_87(id_jr),
        .ex_rs_87(ex_rs), .ex_rt_87(ex_rt),
        .ex_mem_read_87(ex_mem_read), .ex_reg_write_87(ex_reg_write), .ex_dst_87(ex_dst),
        .ex_mul_87(ex_mul),
        .mem_reg_write_87(mem_reg_write), .mem_dst_87(mem_dst),
        .wb_reg_write_87(wb_reg_write), .wb_dst_87(wb_dst),
        .br_taken_87(br_taken),
        .stall_pc_87(obs4[11]), .stall_ifid_87(obs4[10]), .stall_idex_87(obs4[9]),
        .bubble_ex_87(obs4[8]), .flush_ifid_87(obs4[7]), .flush_idex_87(obs4[6]),
        .flush_exmem_87(obs4[5]), .fwd_a_87(obs4[4:3]), .fwd_b_87(obs4[2:1]),
        .busy_87(obs4[0])
    );

    pipe_hazard_ctrl #(.MUL_LAT(1)) dut1 (
        .clk_87(clk), .rst_87(rst),
        .id_rs_87(id_rs), .id_rt_87(id_rt), .id_jr_87(id_jr),
        .ex_rs_87(ex_rs), .ex_rt_87(ex_rt),
        .ex_mem_read_87(ex_mem_read), .ex_reg_write_87(ex_reg_write), .ex_dst_87(ex_dst),
        .ex_mul_87(ex_mul),
        .mem_reg_write_87(mem_reg_write), .mem_dst_87(mem_dst),
        .wb_reg_write_87(wb_reg_write), .wb_dst_87(wb_dst),
        .br_taken_87(br_taken),
        .stall_pc_87(obs1[11]), .stall_ifid_87(obs1[10]), .stall_idex_87(obs1[9]),
        .bubble_ex_87(obs1[8]), .flush_ifid_87(obs1[7]), .flush_idex_87(obs1[6]),
        .flush_exmem_87(obs1[5]), .fwd_a_87(obs1[4:3]), .fwd_b_87(obs1[2:1]),
        .busy_87(obs1[0])
    );

    // Does a pending writer anywhere in EX/MEM/WB target register r?
    function automatic bit pending_write(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        return (ex_reg_write && ex_dst == r) || (mem_reg_write && mem_dst == r) ||
               (wb_reg_write && wb_dst == r);
    endfunction

    function automatic logic [1:0] fwd_code(input logic [4:0] r);
`ifdef FORWARD_EN
        if (r == 5'd0) return 2'd0;
        if (mem_reg_write && mem_dst == r) return 2'd2;
        if (wb_reg_write && wb_dst == r) return 2'd1;
`endif
        return 2'd0;
    endfunction

    // Expected outputs given the number of multiply-wait cycles still owed.
    function automatic logic [11:0] model(input int wait_left);
        logic [11:0] e;
        bit          load_use, jr, raw;
        e        = '0;
        load_use = ex_mem_read && ex_dst != 5'd0 && (ex_dst == id_rs || ex_dst == id_rt);
        jr       = id_jr && id_rs != 5'd0 &&
                   ((ex_reg_write && ex_dst == id_rs) || (mem_reg_write && mem_dst == id_rs));
        raw      = 1'b0;
`ifndef FORWARD_EN
        raw      = pending_write(id_rs) || pending_write(id_rt);
`endif
        if (br_taken)                      e[7:5] = 3'b111;
        else if (wait_left > 0)            begin e[11:9] = 3'b111; e[5] = 1'b1; end
        else if (load_use || jr || raw)    begin e[11:10] = 2'b11; e[8] = 1'b1; end
        e[0]   = (wait_left > 0);
        e[4:3] = fwd_code(ex_rs);
        e[2:1] = fwd_code(ex_rt);
        return e;
    endfunction

    function automatic int next_wait(input int wait_left, input int lat);
        if (rst || br_taken) return 0;
        if (wait_left > 0)   return wait_left - 1;
        if (ex_mul && lat > 1) return lat - 1;
        return 0;
    endfunction

    task automatic chk(input string tag, input logic [11:0] observed, input logic [11:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic clear_inputs();
        rst = 0; id_rs = 0; id_rt = 0; id_jr = 0; ex_rs = 0; ex_rt = 0;
        ex_mem_read = 0; ex_reg_write = 0; ex_dst = 0; ex_mul = 0;
        mem_reg_write = 0; mem_dst = 0; wb_reg_write = 0; wb_dst = 0; br_taken = 0;
    endtask

    // Check both instances against the model, clock once, advance the model.
    task automatic step(input string tag);
        #1;
        chk({tag, "_lat4"}, obs4, model(wait4));
        chk({tag, "_lat1"}, obs1, model(wait1));
        @(posedge clk);
        wait4 = next_wait(wait4, 4);
        wait1 = next_wait(wait1, 1);
        @(negedge clk);
    endtask

    function automatic logic [4:0] rnd_reg();
        logic [4:0] pool [4];
        pool[0] = 5'd0; pool[1] = 5'd3; pool[2] = 5'd7; pool[3] = 5'd31;
        return pool[$urandom_range(0, 3)];
    endfunction

    initial begin
        clear_inputs();
        rst = 1;
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        wait4 = 0; wait1 = 0;
        clear_inputs();

        // Idle after reset: everything low.
        #1 chk("reset_idle", obs4, 12'h000);
        step("reset_idle");

        // Load-use stalls for exactly the hazard cycle.
        ex_mem_read = 1; ex_reg_write = 1; ex_dst = 5'd5; id_rs = 5'd5;
        #1 chk("load_use_stall", 12'(obs4[11:8]), 12'h00D);
        step("load_use");
        clear_inputs();
        #1 chk("load_use_release", 12'(obs4[11:8]), 12'h000);
        step("load_use_after");

        // Multiply: three wait cycles with ID/EX held, then back to RUN.
        ex_mul = 1;
        step("mul_issue");
        clear_inputs();
        for (int i = 0; i < 3; i++) begin
            #1 chk("mul_busy", 12'({obs4[9], obs4[0]}), 12'h003);
            chk("lat1_never_busy", 12'(obs1[0]), 12'h000);
            step("mul_wait");
        end
        #1 chk("mul_done", 12'({obs4[9], obs4[0]}), 12'h000);
        step("mul_done");

        // Branch taken in the second wait cycle.
        ex_mul = 1;
        step("mul_issue2");
        clear_inputs();
        step("mul_wait1");
        br_taken = 1;
        #1 chk("br_flush", 12'(obs4[11:5]), 12'h007);
        step("br_in_wait");
        clear_inputs();
        #1 chk("br_back_to_run", obs4, 12'h000);
        step("br_after");

        // Forwarding priority: MEM beats WB, $0 never forwarded.
        mem_reg_write = 1; wb_reg_write = 1; mem_dst = 5'd7; wb_dst = 5'd7; ex_rs = 5'd7;
`ifdef FORWARD_EN
        #1 chk("fwd_mem", 12'(obs4[4:3]), 12'h002);
`else
        #1 chk("fwd_tied", 12'(obs4[4:3]), 12'h000);
`endif
        step("fwd_rs7");
        mem_dst = 5'd0; wb_dst = 5'd0; ex_rs = 5'd0;
        #1 chk("fwd_r0", 12'(obs4[4:3]), 12'h000);
        step("fwd_r0");
        clear_inputs();

        // JR reading a register still being produced in MEM.
        id_jr = 1; id_rs = 5'd31; mem_reg_write = 1; mem_dst = 5'd31;
        #1 chk("jr_stall", 12'(obs4[11]), 12'h001);
        step("jr_stall");
        mem_reg_write = 0;
        #1 chk("jr_release", 12'(obs4[11]), 12'h000);
        step("jr_release");
        clear_inputs();

        // Reset during a multiply wait.
        ex_mul = 1;
        step("mul_issue3");
        clear_inputs();
        rst = 1;
        step("rst_in_wait");
        rst = 0;
        #1 chk("rst_abort", obs4, 12'h000);
        step("rst_after");

        // MEM-stage producer without a load: stalls only when bypassing is off.
        mem_reg_write = 1; mem_dst = 5'd5; id_rs = 5'd5;
`ifdef FORWARD_EN
        #1 chk("mem_match", 12'(obs4[11]), 12'h000);
`else
        #1 chk("mem_match", 12'(obs4[11]), 12'h001);
`endif
        step("mem_match");
        clear_inputs();
        wb_reg_write = 1; wb_dst = 5'd3; id_rt = 5'd3;
        step("wb_match");
        clear_inputs();

        // Random traffic.
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 63) == 0);
            br_taken      = ($urandom_range(0, 15) == 0);
            ex_mul        = ($urandom_range(0, 9) == 0);
            id_jr         = ($urandom_range(0, 3) == 0);
            ex_mem_read   = ($urandom_range(0, 3) == 0);
            ex_reg_write  = $urandom_range(0, 1) != 0;
            mem_reg_write = $urandom_range(0, 1) != 0;
            wb_reg_write  = $urandom_range(0, 1) != 0;
            id_rs = rnd_reg(); id_rt = rnd_reg(); ex_rs = rnd_reg(); ex_rt = rnd_reg();
            ex_dst = rnd_reg(); mem_dst = rnd_reg(); wb_dst = rnd_reg();
            step("random");
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
